// File: rtl/mdu_sched.sv
// ============================================================================
// Module   : mdu_sched
// Purpose  : Multiply/divide unit scheduler with HI/LO registers and a fixed-
//            latency busy window per operation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_sched #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        done
);

    localparam int c_MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W      = $clog2(c_MAX_CYCLES + 1);

    localparam logic [2:0] c_OP_MULT  = 3'd1;
    localparam logic [2:0] c_OP_MULTU = 3'd2;
    localparam logic [2:0] c_OP_DIV   = 3'd3;
    localparam logic [2:0] c_OP_DIVU  = 3'd4;
    localparam logic [2:0] c_OP_MTHI  = 3'd5;
    localparam logic [2:0] c_OP_MTLO  = 3'd6;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [31:0]          r_pend_hi;
    logic [31:0]          r_pend_lo;
    logic                 r_divz;
    logic [31:0]          r_hi;
    logic [31:0]          r_lo;
    logic                 r_done;

    logic                 w_is_md;
    logic                 w_is_mul;
    logic                 w_is_div;
    logic                 w_accept;
    logic                 w_last;
    logic                 w_rt_nz;
    logic signed [63:0]   w_sprod;
    logic [63:0]          w_uprod;
    logic [31:0]          w_udiv_den;
    logic [31:0]          w_uq;
    logic [31:0]          w_ur;
    logic [31:0]          w_rs_mag;
    logic [31:0]          w_rt_mag;
    logic [31:0]          w_sdiv_den;
    logic [31:0]          w_mq;
    logic [31:0]          w_mr;
    logic [31:0]          w_sq;
    logic [31:0]          w_sr;
    logic [31:0]          w_res_hi;
    logic [31:0]          w_res_lo;

    assign w_is_mul = (op == c_OP_MULT) || (op == c_OP_MULTU);
    assign w_is_div = (op == c_OP_DIV)  || (op == c_OP_DIVU);
    assign w_is_md  = start && (w_is_mul || w_is_div);
    assign w_accept = (r_state == ST_IDLE) && w_is_md;
    assign w_last   = (r_state == ST_RUN) && (r_cnt == c_CNT_W'(1));

    // Divisors are forced to 1 on divide-by-zero; that result is discarded anyway.
    assign w_rt_nz    = (rt_data != 32'd0);
    assign w_sprod    = $signed({{32{rs_data[31]}}, rs_data}) * $signed({{32{rt_data[31]}}, rt_data});
    assign w_uprod    = {32'd0, rs_data} * {32'd0, rt_data};
    assign w_udiv_den = w_rt_nz ? rt_data : 32'd1;
    assign w_uq       = rs_data / w_udiv_den;
    assign w_ur       = rs_data % w_udiv_den;

    // Signed divide on magnitudes; 0x80000000 / -1 wraps back to 0x80000000.
    assign w_rs_mag   = rs_data[31] ? (32'd0 - rs_data) : rs_data;
    assign w_rt_mag   = rt_data[31] ? (32'd0 - rt_data) : rt_data;
    assign w_sdiv_den = w_rt_nz ? w_rt_mag : 32'd1;
    assign w_mq       = w_rs_mag / w_sdiv_den;
    assign w_mr       = w_rs_mag % w_sdiv_den;
    assign w_sq       = (rs_data[31] ^ rt_data[31]) ? (32'd0 - w_mq) : w_mq;
    assign w_sr       = rs_data[31] ? (32'd0 - w_mr) : w_mr;

    always_comb begin
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
        case (op)
            c_OP_MULT:  begin w_res_hi = w_sprod[63:32]; w_res_lo = w_sprod[31:0]; end
            c_OP_MULTU: begin w_res_hi = w_uprod[63:32]; w_res_lo = w_uprod[31:0]; end
            c_OP_DIV:   begin w_res_hi = w_sr;           w_res_lo = w_sq;          end
            c_OP_DIVU:  begin w_res_hi = w_ur;           w_res_lo = w_uq;          end
            default:    begin w_res_hi = 32'd0;          w_res_lo = 32'd0;         end
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last)   w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_divz    <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_pend_hi <= w_res_hi;
                r_pend_lo <= w_res_lo;
                r_divz    <= w_is_div && !w_rt_nz;
                r_cnt     <= w_is_mul ? c_CNT_W'(MUL_CYCLES) : c_CNT_W'(DIV_CYCLES);
            end else if (r_state == ST_RUN) begin
                r_cnt <= r_cnt - c_CNT_W'(1);
                if (w_last) begin
                    r_done <= 1'b1;
                    if (!r_divz) begin
                        r_hi <= r_pend_hi;
                        r_lo <= r_pend_lo;
                    end
                end
            end else if (start && (op == c_OP_MTHI)) begin
                r_hi <= rs_data;
            end else if (start && (op == c_OP_MTLO)) begin
                r_lo <= rs_data;
            end
        end
    end

    assign busy  = (r_state == ST_RUN);
    assign stall = reset && (busy || w_is_md);
    assign hi    = r_hi;
    assign lo    = r_lo;
    assign done  = r_done;

endmodule

`default_nettype wire

// File: tb/tb_mdu_sched.sv
// ============================================================================
// Module   : tb_mdu_sched
// Purpose  : Self-checking bench for mdu_sched against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mdu_sched;

    localparam int MULC = 5;
    localparam int DIVC = 10;

    logic        clk     = 1'b0;
    logic        reset   = 1'b0;
    logic        start   = 1'b0;
    logic [2:0]  op      = 3'd0;
    logic [31:0] rs_data = 32'd0;
    logic [31:0] rt_data = 32'd0;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] m_hi  = 32'd0;
    logic [31:0] m_lo  = 32'd0;

    always #5 clk = ~clk;

    mdu_sched #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .busy    (busy),
        .stall   (stall),
        .hi      (hi),
        .lo      (lo),
        .done    (done)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: plain 64-bit arithmetic on the architectural HI/LO state.
    function automatic void model_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            3'd1: begin q = sa * sb; m_hi = q[63:32]; m_lo = q[31:0]; end
            3'd2: begin p = ua * ub; m_hi = p[63:32]; m_lo = p[31:0]; end
            3'd3: if (b != 32'd0) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
            3'd4: if (b != 32'd0) begin p = ua / ub; m_lo = p[31:0]; p = ua % ub; m_hi = p[31:0]; end
            3'd5: m_hi = a;
            3'd6: m_lo = a;
            default: ;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] o);
        if (o == 3'd1 || o == 3'd2) return MULC;
        if (o == 3'd3 || o == 3'd4) return DIVC;
        return 0;
    endfunction

    // Issues one op for a single cycle and observes the following window.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int nb, output int dix, output int nd, output logic st);
        @(posedge clk); #1;
        start = 1'b1; op = o; rs_data = a; rt_data = b;
        #3;
        st = stall;
        @(posedge clk); #1;
        start = 1'b0; op = 3'd0;
        nb = 0; nd = 0; dix = -1;
        for (int i = 0; i < DIVC + 4; i++) begin
            @(negedge clk);
            if (busy) nb++;
            if (done) begin
                nd++;
                if (dix < 0) dix = i;
            end
        end
    endtask

    task automatic check_op(input string name, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int   nb, dix, nd, n;
        logic st;
        logic exp_st;
        do_op(o, a, b, nb, dix, nd, st);
        model_op(o, a, b);
        n      = exp_lat(o);
        exp_st = (n != 0);
        n_vec++;
        if (nb !== n) begin n_err++; $display("FAIL %s busy_cycles: got %0d expected %0d", name, nb, n); end
        n_vec++;
        if (nd !== ((n != 0) ? 1 : 0)) begin n_err++; $display("FAIL %s done_count: got %0d expected %0d", name, nd, (n != 0) ? 1 : 0); end
        n_vec++;
        if (dix !== ((n != 0) ? n : -1)) begin n_err++; $display("FAIL %s done_cycle: got %0d expected %0d", name, dix, (n != 0) ? n : -1); end
        n_vec++;
        if (st !== exp_st) begin n_err++; $display("FAIL %s stall: got %b expected %b", name, st, exp_st); end
        n_vec++;
        if (hi !== m_hi) begin n_err++; $display("FAIL %s hi: got %h expected %h", name, hi, m_hi); end
        n_vec++;
        if (lo !== m_lo) begin n_err++; $display("FAIL %s lo: got %h expected %h", name, lo, m_lo); end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b1; op = 3'd1; rs_data = 32'h7; rt_data = 32'h9;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++; if (busy  !== 1'b0)  begin n_err++; $display("FAIL reset busy: got %b expected 0", busy); end
        n_vec++; if (done  !== 1'b0)  begin n_err++; $display("FAIL reset done: got %b expected 0", done); end
        n_vec++; if (stall !== 1'b0)  begin n_err++; $display("FAIL reset stall: got %b expected 0", stall); end
        n_vec++; if (hi    !== 32'd0) begin n_err++; $display("FAIL reset hi: got %h expected 0", hi); end
        n_vec++; if (lo    !== 32'd0) begin n_err++; $display("FAIL reset lo: got %h expected 0", lo); end
        start = 1'b0; op = 3'd0;
        reset = 1'b1;
        m_hi = 32'd0; m_lo = 32'd0;
    endtask

    task automatic test_directed();
        check_op("mult_neg",  3'd1, 32'hFFFFFFFE, 32'd3);
        n_vec++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin n_err++; $display("FAIL mult_neg_const: got %h_%h expected ffffffff_fffffffa", hi, lo); end
        check_op("multu_max", 3'd2, 32'hFFFFFFFF, 32'd2);
        n_vec++; if (hi !== 32'h1 || lo !== 32'hFFFFFFFE) begin n_err++; $display("FAIL multu_const: got %h_%h expected 00000001_fffffffe", hi, lo); end
        check_op("div_neg",   3'd3, 32'hFFFFFFF9, 32'd2);
        n_vec++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin n_err++; $display("FAIL div_neg_const: got %h_%h expected ffffffff_fffffffd", hi, lo); end
        check_op("div_ovf",   3'd3, 32'h80000000, 32'hFFFFFFFF);
        n_vec++; if (hi !== 32'h0 || lo !== 32'h80000000) begin n_err++; $display("FAIL div_ovf_const: got %h_%h expected 00000000_80000000", hi, lo); end
        check_op("divu",      3'd4, 32'hFFFFFFF0, 32'd7);
    endtask

    task automatic test_divzero();
        check_op("mthi_11",  3'd5, 32'h11, 32'd0);
        check_op("mtlo_22",  3'd6, 32'h22, 32'd0);
        check_op("divu_z",   3'd4, 32'h12345, 32'd0);
        n_vec++; if (hi !== 32'h11 || lo !== 32'h22) begin n_err++; $display("FAIL divu_z_const: got %h_%h expected 00000011_00000022", hi, lo); end
        check_op("div_z",    3'd3, 32'h80000000, 32'd0);
    endtask

    task automatic test_nop();
        check_op("op_none",  3'd0, 32'hAAAA5555, 32'h3);
        check_op("op_rsvd",  3'd7, 32'h5555AAAA, 32'h3);
    endtask

    task automatic test_back_to_back();
        int nb = 0, nd = 0;
        @(posedge clk); #1;
        start = 1'b1; op = 3'd5; rs_data = 32'h1234;
        @(negedge clk); if (busy) nb++; if (done) nd++;
        @(posedge clk); #1;
        op = 3'd6; rs_data = 32'h5678;
        @(negedge clk); if (busy) nb++; if (done) nd++;
        @(posedge clk); #1;
        start = 1'b0; op = 3'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); if (busy) nb++; if (done) nd++;
        end
        model_op(3'd5, 32'h1234, 32'd0);
        model_op(3'd6, 32'h5678, 32'd0);
        n_vec++; if (nb !== 0) begin n_err++; $display("FAIL mtx_b2b busy: got %0d expected 0", nb); end
        n_vec++; if (nd !== 0) begin n_err++; $display("FAIL mtx_b2b done: got %0d expected 0", nd); end
        n_vec++; if (hi !== m_hi) begin n_err++; $display("FAIL mtx_b2b hi: got %h expected %h", hi, m_hi); end
        n_vec++; if (lo !== m_lo) begin n_err++; $display("FAIL mtx_b2b lo: got %h expected %h", lo, m_lo); end
    endtask

    task automatic test_ignore_in_run();
        int   nb = 0, nd = 0, dix = -1;
        logic st_ok = 1'b1;
        @(posedge clk); #1;
        start = 1'b1; op = 3'd3; rs_data = 32'd1000; rt_data = 32'd7;
        @(posedge clk); #1;
        start = 1'b0; op = 3'd0;
        for (int i = 0; i < DIVC + 4; i++) begin
            @(negedge clk);
            if (busy) nb++;
            if (done) begin nd++; if (dix < 0) dix = i; end
            if (i == 1 || i == 2) st_ok = st_ok && (stall === 1'b1);
            if (i == 0) begin start = 1'b1; op = 3'd1; rs_data = 32'h00FF00FF; rt_data = 32'h13; end
            if (i == 1) begin op = 3'd5; rs_data = 32'hDEADBEEF; end
            if (i == 2) begin start = 1'b0; op = 3'd0; end
        end
        model_op(3'd3, 32'd1000, 32'd7);
        n_vec++; if (nb !== DIVC) begin n_err++; $display("FAIL ignore busy: got %0d expected %0d", nb, DIVC); end
        n_vec++; if (dix !== DIVC || nd !== 1) begin n_err++; $display("FAIL ignore done: got idx %0d cnt %0d expected idx %0d cnt 1", dix, nd, DIVC); end
        n_vec++; if (st_ok !== 1'b1) begin n_err++; $display("FAIL ignore stall: got %b expected 1", st_ok); end
        n_vec++; if (hi !== m_hi || lo !== m_lo) begin n_err++; $display("FAIL ignore result: got %h_%h expected %h_%h", hi, lo, m_hi, m_lo); end
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [31:0] a, b;
        for (int k = 0; k < 24; k++) begin
            o = 3'($urandom_range(1, 6));
            a = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 9));
                2:       b = 32'hFFFFFFFF;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) a = 32'h80000000;
            check_op("random", o, a, b);
        end
    endtask

    task automatic test_reset_midrun();
        int nb = 0, nd = 0;
        @(posedge clk); #1;
        start = 1'b1; op = 3'd3; rs_data = 32'h7FFF0000; rt_data = 32'd3;
        @(posedge clk); #1;
        start = 1'b0; op = 3'd0;
        for (int i = 0; i < DIVC + 4; i++) begin
            @(negedge clk);
            if (i > 2) begin
                if (busy) nb++;
                if (done) nd++;
            end
            if (i == 2) begin
                #1 reset = 1'b0;
                #1;
                n_vec++; if (hi !== 32'd0 || lo !== 32'd0) begin n_err++; $display("FAIL midrun_reset hilo: got %h_%h expected 0_0", hi, lo); end
                n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrun_reset busy: got %b expected 0", busy); end
            end
            if (i == 4) reset = 1'b1;
        end
        m_hi = 32'd0; m_lo = 32'd0;
        n_vec++; if (nb !== 0) begin n_err++; $display("FAIL midrun_after busy: got %0d expected 0", nb); end
        n_vec++; if (nd !== 0) begin n_err++; $display("FAIL midrun_after done: got %0d expected 0", nd); end
        n_vec++; if (hi !== m_hi || lo !== m_lo) begin n_err++; $display("FAIL midrun_after hilo: got %h_%h expected 0_0", hi, lo); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_divzero();
        test_nop();
        test_back_to_back();
        test_ignore_in_run();
        test_random();
        test_reset_midrun();
        check_op("post_reset_mult", 3'd1, 32'h00010001, 32'hFFFFFFFF);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
